// File: rtl/microwave_pkg.sv
// ============================================================================
// Module : microwave_pkg
// Brief  : Shared types and States bit indices for the cook-time countdown.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package microwave_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } timer_state_t;

    localparam int ST_START = 3;
    localparam int ST_CLOSE = 2;
    localparam int ST_HEAT  = 1;
    localparam int ST_ERROR = 0;

    typedef struct packed {
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } bcd_time_t;

endpackage

`default_nettype wire

// File: rtl/mw_tick_prescaler.sv
// ============================================================================
// Module : mw_tick_prescaler
// Brief  : Divides clk down to a one-cycle sec_tick; count is held while en=0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mw_tick_prescaler #(
    parameter int TICKS_PER_SEC = 10
) (
    input  logic clk,
    input  logic sys_reset,
    input  logic clr,
    input  logic en,
    output logic sec_tick
);

    localparam int CW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] C_TERM = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign sec_tick = en && (count_q == C_TERM);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = sec_tick ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/microwave_timer.sv
// ============================================================================
// Module : microwave_timer
// Brief  : BCD mm:ss keypad entry and per-second countdown gated by Heat.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module microwave_timer
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 10,
    parameter int MAX_MIN_TENS  = 9
) (
    input  logic        clk,
    input  logic        sys_reset,
    input  logic [3:0]  States,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        clear,
    output logic        done,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic [2:0]  timer_state
);

    localparam bcd_time_t C_ONE_SEC = '{m1: 4'd0, m0: 4'd0, s1: 4'd0, s0: 4'd1};

    timer_state_t state_q, state_d;
    bcd_time_t    time_q, time_d;
    logic         presc_clr;
    logic         presc_en;
    logic         w_sec_tick;
    logic         w_heat;
    logic         w_error;
    logic         unused_states;

    assign w_heat        = States[ST_HEAT];
    assign w_error       = States[ST_ERROR];
    assign unused_states = &{1'b0, States[ST_START], States[ST_CLOSE]};

    // Seconds borrow into minutes reloads 59, even when s1 was entered as 6-9.
    function automatic bcd_time_t bcd_dec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s0 != 4'd0) begin
            r.s0 = t.s0 - 4'd1;
        end else if (t.s1 != 4'd0) begin
            r.s1 = t.s1 - 4'd1;
            r.s0 = 4'd9;
        end else if ({t.m1, t.m0} != 8'd0) begin
            r.s1 = 4'd5;
            r.s0 = 4'd9;
            if (t.m0 != 4'd0) begin
                r.m0 = t.m0 - 4'd1;
            end else begin
                r.m0 = 4'd9;
                r.m1 = t.m1 - 4'd1;
            end
        end
        return r;
    endfunction

    function automatic bcd_time_t bcd_shift(input bcd_time_t t, input logic [3:0] d);
        bcd_time_t r;
        r.m1 = (t.m0 > 4'(MAX_MIN_TENS)) ? 4'(MAX_MIN_TENS) : t.m0;
        r.m0 = t.s1;
        r.s1 = t.s0;
        r.s0 = d;
        return r;
    endfunction

    mw_tick_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_prescaler (
        .clk       (clk),
        .sys_reset (sys_reset),
        .clr       (presc_clr),
        .en        (presc_en),
        .sec_tick  (w_sec_tick)
    );

    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        presc_clr = 1'b0;
        presc_en  = 1'b0;
        case (state_q)
            IDLE, ENTRY: begin
                if (clear) begin
                    state_d = IDLE;
                    time_d  = '0;
                end else if (w_heat) begin
                    if (time_q != '0) begin
                        state_d   = RUN;
                        presc_clr = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else if (key_valid && (key_digit <= 4'd9)) begin
                    time_d  = bcd_shift(time_q, key_digit);
                    state_d = ENTRY;
                end
            end
            RUN: begin
                // Prescaler is left untouched on the pausing cycle so resume continues the second.
                if (!w_heat || w_error) begin
                    state_d = PAUSE;
                end else begin
                    presc_en = 1'b1;
                    if (w_sec_tick) begin
                        time_d = bcd_dec(time_q);
                        if (time_q == C_ONE_SEC) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            PAUSE: begin
                if (clear) begin
                    state_d = IDLE;
                    time_d  = '0;
                end else if (w_heat && !w_error) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                time_d = '0;
                if (clear || !w_heat) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                time_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            state_q <= IDLE;
            time_q  <= '0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
        end
    end

    assign done        = (state_q == DONE);
    assign running     = (state_q == RUN);
    assign time_bcd    = time_q;
    assign timer_state = state_q;

endmodule

`default_nettype wire

// File: doc/microwave_timer.md
Name: microwave_timer

Overview:
- Cook-time countdown stage directly upstream of the microwave controller.
- Takes keypad digits into a BCD mm:ss register and counts down once per second while the controller reports Heat.
- Drives the controller's done input when time expires.
- Consumes the controller's 4-bit States vector: bit3 Start, bit2 Close, bit1 Heat, bit0 Error.

Parameters:
TICKS_PER_SEC, 10, clk cycles per cook second (prescaler terminal count); must be >= 2.
MAX_MIN_TENS, 9, largest accepted minutes-tens digit; a larger digit shifted into m1 saturates to this value.

Ports:
clk  input  1  single system clock; all state on rising edge.
sys_reset  input  1  synchronous, active-high reset.
States  input  4  controller state {Start,Close,Heat,Error}.
key_valid  input  1  one-cycle strobe, key_digit valid.
key_digit  input  4  binary digit 0-9; values 10-15 ignored.
clear  input  1  one-cycle strobe, abort/clear entry.
done  output  1  level to controller, cook time expired.
time_bcd  output  16  {m1,m0,s1,s0} remaining time, BCD.
running  output  1  high in RUN.
timer_state  output  3  current FSM state encoding (debug).

Behaviour:
- Reset: sync on sys_reset. State IDLE, time_bcd=0, prescaler=0, done=0, running=0. Reset wins over every other input in the same cycle, including mid-RUN.
- States: IDLE, ENTRY, RUN, PAUSE, DONE. Heat = States[1], Error = States[0].
- Key entry: accepted only in IDLE/ENTRY. Valid digit d performs shift-in {m1,m0,s1,s0} <= {m0,s1,s0,d}; IDLE -> ENTRY.
  - Digits >9 are ignored.
  - s1 may legally hold 6-9 (e.g. 0:90 = 90 s).
- IDLE/ENTRY:
  - Heat=1 with time!=0 -> RUN next cycle; prescaler cleared.
  - Heat=1 with time==0 -> DONE.
  - Heat and key_valid in the same cycle: Heat wins, key dropped.
- RUN:
  - running=1. Prescaler increments each cycle. Terminal count TICKS_PER_SEC-1 produces sec_tick and wraps to 0.
  - BCD decrement on sec_tick:
    - s0!=0: s0-1.
    - Else if s1!=0: s1-1, s0=9.
    - Else if minutes!=0: s1=5, s0=9, minutes decrement with the same borrow rule (m0 0 -> 9, m1-1).
  - Tick at time 00:01 -> time 00:00 and DONE on the same edge. done=1 from the next cycle.
  - Latency from RUN entry to first decrement: exactly TICKS_PER_SEC cycles.
  - Heat=0 or Error=1 -> PAUSE. Prescaler value is held, not cleared, and no tick is taken that cycle.
  - key_valid and clear are ignored in RUN.
- PAUSE:
  - Prescaler and time frozen.
  - Heat=1 with Error=0 -> RUN, resuming from the held prescaler.
  - clear -> IDLE, time=0.
  - Keys ignored.
- DONE:
  - done=1, time=0.
  - Stays until Heat=0, then IDLE; done drops on the cycle IDLE is entered.
  - clear also -> IDLE.
- clear in IDLE/ENTRY: time=0, state IDLE. clear and key_valid in the same cycle: clear wins.
- Max time 99:99, treated as 99 min + 99 s. No overflow is possible since the counter only counts down.

Decomposition:
- Shared package microwave_pkg:
  - typedef enum logic [2:0] timer_state_t (IDLE=0, ENTRY=1, RUN=2, PAUSE=3, DONE=4).
  - localparams ST_START=3, ST_CLOSE=2, ST_HEAT=1, ST_ERROR=0 (bit indices into States).
  - typedef struct packed bcd_time_t {m1,m0,s1,s0}.
- One sub-module mw_tick_prescaler: parameter TICKS_PER_SEC, inputs clk/sys_reset/clr/en, output sec_tick. Holds its count when en=0.
- BCD decrement and shift-in stay in the top as functions.

Test Plan (TICKS_PER_SEC=4):
- Keys 1,3,0 then States=0110 -> time_bcd 0x0130. First tick after 4 cycles gives 0x0129. After 90 ticks time reaches 0x0000, done=1 the cycle after the final tick. States=0000 -> done=0 and state IDLE next cycle.
- Keys 9,0 (00:90), Heat on -> decrements 0x0090, 0x0089 … 0x0001, 0x0000: 90 ticks, no 0x005x jump until s1 naturally reaches 5.
- Run 00:10. Drop Heat after 6 cycles (1 tick taken, prescaler=2) -> PAUSE, time 0x0009 frozen 20 cycles. Heat back -> next tick after exactly 2 cycles.
- RUN with States=1111 (Error) -> PAUSE. Then clear -> IDLE, time 0x0000, running=0.
- Heat=1 in IDLE with time 0 -> DONE next cycle, done=1. Key_digit 12 in ENTRY -> time unchanged. key_valid+clear in the same cycle -> time 0.
- sys_reset asserted mid-RUN at 0x0105 -> next cycle IDLE, time 0, done=0, running=0, regardless of Heat.
